uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter with an integrated transmit FIFO. It is the next-generation serial TX stage of the edge-detector FPGA design. Data width, parity mode, stop-bit count and bit period are configurable at elaboration. Bytes queued by the processing pipeline are sent back-to-back with no idle gap, so the pipeline never has to wait for a frame to finish before presenting the next byte.

## Interface
Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit (≥2; 87 = 10 MHz / 115200 baud)
- DATA_BITS, 8, payload bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 16, TX FIFO entries (power of 2, ≥2)

Ports:
- i_Clock  in  1  system clock; all logic is on the rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Tx_DV  in  1  write strobe; i_Tx_Byte is pushed when i_Tx_DV && o_Tx_Ready
- i_Tx_Byte  in  DATA_BITS  payload; sent LSB first
- o_Tx_Ready  out  1  FIFO not full
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  entries currently queued
- o_Overflow  out  1  1-cycle pulse when i_Tx_DV is sampled while FIFO is full (byte dropped)
- o_Tx_Active  out  1  high while any frame bit is on the line
- o_Tx_Serial  out  1  serial line; idles high
- o_Tx_Done  out  1  1-cycle pulse after each frame's last stop bit

## Operation
- Frame: start bit (0), DATA_BITS payload bits LSB first, optional parity bit, then STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Parity: odd mode makes (payload ones + parity) odd; even mode makes it even.
- FSM states and transitions:
  - IDLE → START when o_Fifo_Count>0. The FIFO head is popped into the shift register on the same edge.
  - START → DATA.
  - DATA → PARITY if PARITY≠0, else → STOP, after DATA_BITS bits.
  - PARITY → STOP.
  - STOP → START if the FIFO is non-empty at the final stop cycle (pop on that edge); else → IDLE.
- Counters: the bit-period counter is $clog2(CLKS_PER_BIT) wide and wraps to 0 at CLKS_PER_BIT-1. The bit index is $clog2(DATA_BITS) wide (minimum 1 bit). Neither counter exceeds its terminal value.
- FIFO: circular buffer whose read/write pointers wrap modulo FIFO_DEPTH.
  - o_Tx_Ready = (count < FIFO_DEPTH), derived from the registered count.
  - Push into a full FIFO is rejected even if a pop occurs in the same cycle; o_Overflow pulses.
  - Simultaneous push and pop: count unchanged; both take effect.
  - Pop from an empty FIFO never occurs.
- o_Tx_Active stays continuously high across back-to-back frames.

## Timing
- Reset values (cycle after reset is sampled): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Tx_Ready=1, o_Fifo_Count=0. FSM is in IDLE and FIFO pointers are 0.
- Reset mid-frame aborts the frame and discards all queued data. The line goes high on the next cycle; no o_Tx_Done is generated.
- Latency into an empty FIFO with the FSM in IDLE:
  - edge k samples i_Tx_DV; o_Fifo_Count becomes 1 after edge k.
  - edge k+1 pops; o_Tx_Serial goes low and o_Tx_Active goes high after edge k+1.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- o_Tx_Done is registered: high for the single cycle after the last stop-bit cycle.
  - Back-to-back: this coincides with the first start-bit cycle of the next frame.
  - Otherwise: o_Tx_Active is already 0 in that cycle.
- o_Overflow is registered: high for the cycle after the rejected write.
- o_Fifo_Count and o_Tx_Ready update one cycle after the push/pop edge.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated.
- 8N1, push 0x21 once:
  - o_Tx_Serial holds each level 4 cycles: 0,1,0,0,0,0,1,0,0,1.
  - Active is high exactly 40 cycles; one Done pulse follows.
- Parity with 0x21:
  - PARITY=2, STOP_BITS=2: frame is 48 cycles with parity bit 0.
  - PARITY=1: parity bit is 1.
  - DATA_BITS=5 with 0x15: payload 1,0,1,0,1.
- Back-to-back: push 0x55, 0xAA, 0x0F on consecutive cycles.
  - Active is continuously high for 120 cycles with no high gap between stop and start.
  - Three Done pulses, 40 cycles apart.
- Overflow: push 6 bytes on consecutive cycles from IDLE.
  - Pushes 1–5 are accepted (first is popped at cycle 2); push 6 is rejected.
  - o_Overflow pulses once, Ready=0 while count=4.
  - Exactly 5 frames are sent, in order.
- Reset mid-frame: assert i_Reset during bit 3 of frame 1 with 2 bytes queued.
  - Next cycle: Serial=1, Active=0, Count=0, Ready=1; no Done pulse.
  - A later push of 0xC3 transmits a correct frame.
- Simultaneous push/pop with count=2 at the stop→start edge: count stays 2 and no byte is lost or duplicated.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
//   Bundles the byte-write handshake and the serial/status outputs of
//   uart_tx_param. The DATA_BITS and FIFO_DEPTH values must match those of
//   the attached transmitter.
//   master : the byte producer. It drives i_Tx_DV and i_Tx_Byte and watches the status.
//   slave  : the transmitter. It drives o_Tx_Ready, o_Fifo_Count, o_Overflow,
//            o_Tx_Active, o_Tx_Serial and o_Tx_Done.
interface uart_tx_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;

   logic                 i_Tx_DV;
   logic [DATA_BITS-1:0] i_Tx_Byte;
   logic                 o_Tx_Ready;
   logic [NW-1:0]        o_Fifo_Count;
   logic                 o_Overflow;
   logic                 o_Tx_Active;
   logic                 o_Tx_Serial;
   logic                 o_Tx_Done;

   modport master (
      output i_Tx_DV, i_Tx_Byte,
      input  o_Tx_Ready, o_Fifo_Count, o_Overflow, o_Tx_Active, o_Tx_Serial, o_Tx_Done
   );

   modport slave (
      input  i_Tx_DV, i_Tx_Byte,
      output o_Tx_Ready, o_Fifo_Count, o_Overflow, o_Tx_Active, o_Tx_Serial, o_Tx_Done
   );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   UART transmitter with a built-in TX FIFO. Queued bytes go out back-to-back
//   with no idle gap between frames.
//   Frame format: start(0), DATA_BITS payload bits LSB first, optional parity,
//   then STOP_BITS stop bits(1).
//   i_Clock : system clock, rising edge
//   i_Reset : synchronous active-high reset. It aborts any frame and flushes the FIFO.
//   bus     : slave side of uart_tx_param_if (write strobe/byte in, serial and status out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high. Waits for a queued byte.
// S_START  | driving the start bit.
// S_DATA   | shifting payload bits out, LSB first.
// S_PARITY | driving the parity bit (only when PARITY != 0).
// S_STOP   | driving the stop bit(s). On the last cycle, chains straight into the next frame.
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input logic            i_Clock,
   input logic            i_Reset,
   uart_tx_param_if.slave bus
);
   localparam int   CBW = $clog2(CLKS_PER_BIT);
   localparam int   IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int   AW  = $clog2(FIFO_DEPTH);
   localparam int   NW  = AW + 1;
   localparam logic ODD = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [NW-1:0]        count_q;
   logic                 full, push, pop, overflow_q;
   logic [DATA_BITS-1:0] head;

   assign full = (count_q == NW'(FIFO_DEPTH));
   // Fullness comes from the registered count, so a push into a full FIFO is
   // refused even if a pop frees a slot on the same edge.
   assign push = bus.i_Tx_DV && !full;
   assign head = mem[rd_ptr];

   always_ff @(posedge i_Clock) begin
      if (push) mem[wr_ptr] <= bus.i_Tx_Byte;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + NW'(1);
            2'b01:   count_q <= count_q - NW'(1);
            default: count_q <= count_q;
         endcase
         overflow_q <= bus.i_Tx_DV && full;
      end
   end

   // Transmit FSM
   state_t               state_q, state_d;
   logic [CBW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   assign bit_end = (cnt_q == CBW'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   // The line level is registered. Each transition therefore loads the level
   // of the bit being entered.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      par_d    = par_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;
      pop      = 1'b0;

      if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + CBW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d  = S_DATA;
               idx_d    = '0;
               serial_d = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  idx_d = '0;
                  if (PARITY != 0) begin
                     state_d  = S_PARITY;
                     serial_d = par_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  idx_d    = idx_q + IW'(1);
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d  = S_STOP;
               idx_d    = '0;
               serial_d = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  if (count_q != '0) begin
                     pop = 1'b1;
                  end else begin
                     state_d  = S_IDLE;
                     serial_d = 1'b1;
                     active_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Popping always starts a frame, both from idle and when chaining
      // directly out of the last stop cycle.
      if (pop) begin
         shift_d  = head;
         par_d    = (^head) ^ ODD;
         state_d  = S_START;
         cnt_d    = '0;
         idx_d    = '0;
         serial_d = 1'b0;
         active_d = 1'b1;
      end
   end

   assign bus.o_Tx_Ready   = !full;
   assign bus.o_Fifo_Count = count_q;
   assign bus.o_Overflow   = overflow_q;
   assign bus.o_Tx_Active  = active_q;
   assign bus.o_Tx_Serial  = serial_q;
   assign bus.o_Tx_Done    = done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   typedef struct {
      int         lane;
      logic [8:0] data;
      logic       par;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus0 ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus1 ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus2 ();
   uart_tx_param_if #(.DATA_BITS(5), .FIFO_DEPTH(DEPTH)) bus3 ();

   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
      u_8n1 (.i_Clock(clk), .i_Reset(rst), .bus(bus0));
   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
      u_8e2 (.i_Clock(clk), .i_Reset(rst), .bus(bus1));
   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
      u_8o1 (.i_Clock(clk), .i_Reset(rst), .bus(bus2));
   uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
      u_5n1 (.i_Clock(clk), .i_Reset(rst), .bus(bus3));

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // monitor-owned state
   int   cyc = 0;
   bit   in_frame [4];
   int   pos      [4];
   int   bad_pos  [4];
   bit   ferr     [4];
   exp_t cur      [4];
   bit   act_prev [4];
   int   act_cyc  [4];
   int   act_rise [4];
   int   done_cnt [4];
   int   done_act [4];
   int   ovf_cnt  [4];
   int   done_t0[$];

   // lane configuration: data bits, parity mode, stop bits
   function automatic int dbits(int l);
      return (l == 3) ? 5 : 8;
   endfunction
   function automatic int pmode(int l);
      return (l == 1) ? 2 : (l == 2) ? 1 : 0;
   endfunction
   function automatic int sbits(int l);
      return (l == 1) ? 2 : 1;
   endfunction
   function automatic int flen(int l);
      return CPB * (1 + dbits(l) + ((pmode(l) != 0) ? 1 : 0) + sbits(l));
   endfunction

   function automatic logic ser_of(int l);
      case (l)
         0: return bus0.o_Tx_Serial;
         1: return bus1.o_Tx_Serial;
         2: return bus2.o_Tx_Serial;
         default: return bus3.o_Tx_Serial;
      endcase
   endfunction
   function automatic logic act_of(int l);
      case (l)
         0: return bus0.o_Tx_Active;
         1: return bus1.o_Tx_Active;
         2: return bus2.o_Tx_Active;
         default: return bus3.o_Tx_Active;
      endcase
   endfunction
   function automatic logic done_of(int l);
      case (l)
         0: return bus0.o_Tx_Done;
         1: return bus1.o_Tx_Done;
         2: return bus2.o_Tx_Done;
         default: return bus3.o_Tx_Done;
      endcase
   endfunction
   function automatic logic ovf_of(int l);
      case (l)
         0: return bus0.o_Overflow;
         1: return bus1.o_Overflow;
         2: return bus2.o_Overflow;
         default: return bus3.o_Overflow;
      endcase
   endfunction
   function automatic int cnt_of(int l);
      case (l)
         0: return int'(bus0.o_Fifo_Count);
         1: return int'(bus1.o_Fifo_Count);
         2: return int'(bus2.o_Fifo_Count);
         default: return int'(bus3.o_Fifo_Count);
      endcase
   endfunction

   // expected line level for bit slot b of a frame
   function automatic logic lvl(int l, exp_t e, int b);
      if (b == 0) return 1'b0;
      if (b <= dbits(l)) return e.data[b-1];
      if (pmode(l) != 0 && b == dbits(l) + 1) return e.par;
      return 1'b1;
   endfunction

   task automatic check(string nm, int got, int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, want, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int l, logic dv, logic [8:0] b);
      case (l)
         0: begin bus0.i_Tx_DV = dv; bus0.i_Tx_Byte = b[7:0]; end
         1: begin bus1.i_Tx_DV = dv; bus1.i_Tx_Byte = b[7:0]; end
         2: begin bus2.i_Tx_DV = dv; bus2.i_Tx_Byte = b[7:0]; end
         default: begin bus3.i_Tx_DV = dv; bus3.i_Tx_Byte = b[4:0]; end
      endcase
   endtask

   task automatic expect_frame(int l, logic [8:0] d, logic p);
      exp_t e;
      e.lane = l;
      e.data = d;
      e.par  = p;
      exp_q.push_back(e);
   endtask

   task automatic push1(int l, logic [8:0] b);
      drive(l, 1'b1, b);
      tick();
      drive(l, 1'b0, 9'h0);
   endtask

   task automatic wait_idle(int l, int budget);
      int n = 0;
      while (!(act_of(l) == 1'b0 && cnt_of(l) == 0 && exp_q.size() == 0 && !in_frame[l])
             && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout lane %0d: still busy after %0d cycles, expected idle", l, budget);
      end
      repeat (3) tick();
   endtask

   // Decodes every lane's line at the falling edge and scores each frame
   // against the head of the expected queue.
   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         for (int l = 0; l < 4; l++) begin
            logic s, a;
            s = ser_of(l);
            a = act_of(l);
            if (rst) begin
               in_frame[l] = 1'b0;
               act_prev[l] = 1'b0;
            end else begin
               if (a) act_cyc[l]++;
               if (a && !act_prev[l]) act_rise[l]++;
               act_prev[l] = a;
               if (done_of(l)) begin
                  done_cnt[l]++;
                  if (a) done_act[l]++;
                  if (l == 0) done_t0.push_back(cyc);
               end
               if (ovf_of(l)) ovf_cnt[l]++;
               if (!in_frame[l] && s == 1'b0) begin
                  if (exp_q.size() == 0) begin
                     cur[l].lane = -1;
                     cur[l].data = 9'h0;
                     cur[l].par  = 1'b0;
                  end else begin
                     cur[l] = exp_q.pop_front();
                  end
                  in_frame[l] = 1'b1;
                  pos[l]      = 0;
                  ferr[l]     = 1'b0;
                  bad_pos[l]  = -1;
               end
               if (in_frame[l]) begin
                  if (s !== lvl(l, cur[l], pos[l] / CPB) && !ferr[l]) begin
                     ferr[l]    = 1'b1;
                     bad_pos[l] = pos[l];
                  end
                  pos[l]++;
                  if (pos[l] == flen(l)) begin
                     in_frame[l] = 1'b0;
                     n_checks++;
                     if (ferr[l] || cur[l].lane != l) begin
                        n_fail++;
                        $display("FAIL frame lane %0d: first wrong level at cycle %0d, queued lane %0d byte 0x%0h",
                                 l, bad_pos[l], cur[l].lane, cur[l].data);
                     end
                  end
               end
            end
         end
      end
   endtask

   initial begin
      int a0, r0, d0, da0, o0, nt, g1, g2;
      for (int l = 0; l < 4; l++) drive(l, 1'b0, 9'h0);
      fork
         monitor();
      join_none

      // reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_serial", int'(bus0.o_Tx_Serial), 1);
      check("rst_active", int'(bus0.o_Tx_Active), 0);
      check("rst_done", int'(bus0.o_Tx_Done), 0);
      check("rst_overflow", int'(bus0.o_Overflow), 0);
      check("rst_ready", int'(bus0.o_Tx_Ready), 1);
      check("rst_count", cnt_of(0), 0);
      rst = 1'b0;
      tick();

      // 8N1 single byte 0x21 -> 0,1,0,0,0,0,1,0,0,1
      a0 = act_cyc[0]; d0 = done_cnt[0]; da0 = done_act[0];
      expect_frame(0, 9'h021, 1'b0);
      push1(0, 9'h021);
      check("lat_count", cnt_of(0), 1);
      check("lat_serial_before", int'(bus0.o_Tx_Serial), 1);
      tick();
      check("lat_serial_start", int'(bus0.o_Tx_Serial), 0);
      check("lat_active", int'(bus0.o_Tx_Active), 1);
      wait_idle(0, 200);
      check("single_active_cycles", act_cyc[0] - a0, 40);
      check("single_done_pulses", done_cnt[0] - d0, 1);
      check("single_done_while_active", done_act[0] - da0, 0);

      // parity / width variants
      a0 = act_cyc[1];
      expect_frame(1, 9'h021, 1'b0);
      push1(1, 9'h021);
      wait_idle(1, 200);
      check("8e2_active_cycles", act_cyc[1] - a0, 48);
      a0 = act_cyc[2];
      expect_frame(2, 9'h021, 1'b1);
      push1(2, 9'h021);
      wait_idle(2, 200);
      check("8o1_active_cycles", act_cyc[2] - a0, 44);
      a0 = act_cyc[3];
      expect_frame(3, 9'h015, 1'b0);
      push1(3, 9'h015);
      wait_idle(3, 200);
      check("5n1_active_cycles", act_cyc[3] - a0, 28);

      // back-to-back 0x55, 0xAA, 0x0F
      a0 = act_cyc[0]; r0 = act_rise[0]; d0 = done_cnt[0]; da0 = done_act[0];
      nt = done_t0.size();
      expect_frame(0, 9'h055, 1'b0);
      expect_frame(0, 9'h0AA, 1'b0);
      expect_frame(0, 9'h00F, 1'b0);
      drive(0, 1'b1, 9'h055); tick();
      drive(0, 1'b1, 9'h0AA); tick();
      drive(0, 1'b1, 9'h00F); tick();
      drive(0, 1'b0, 9'h0);
      wait_idle(0, 400);
      check("b2b_active_cycles", act_cyc[0] - a0, 120);
      check("b2b_active_rises", act_rise[0] - r0, 1);
      check("b2b_done_pulses", done_cnt[0] - d0, 3);
      check("b2b_done_on_start", done_act[0] - da0, 2);
      g1 = -1; g2 = -1;
      if (done_t0.size() >= nt + 3) begin
         g1 = done_t0[nt+1] - done_t0[nt];
         g2 = done_t0[nt+2] - done_t0[nt+1];
      end
      check("b2b_done_gap1", g1, 40);
      check("b2b_done_gap2", g2, 40);

      // overflow: six consecutive pushes into a depth-4 FIFO
      o0 = ovf_cnt[0];
      for (int i = 0; i < 5; i++) expect_frame(0, 9'(i + 1), 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1'b1, 9'(i + 1));
         tick();
         if (i == 4) begin
            check("ovf_count_full", cnt_of(0), 4);
            check("ovf_ready_low", int'(bus0.o_Tx_Ready), 0);
         end
         if (i == 5) check("ovf_pulse", int'(bus0.o_Overflow), 1);
      end
      drive(0, 1'b0, 9'h0);
      tick();
      check("ovf_pulse_end", int'(bus0.o_Overflow), 0);
      wait_idle(0, 600);
      check("ovf_pulse_count", ovf_cnt[0] - o0, 1);

      // push coinciding with the stop->start pop at count 2
      expect_frame(0, 9'h03C, 1'b0);
      expect_frame(0, 9'h05A, 1'b0);
      expect_frame(0, 9'h096, 1'b0);
      expect_frame(0, 9'h0E7, 1'b0);
      drive(0, 1'b1, 9'h03C); tick();
      drive(0, 1'b1, 9'h05A); tick();
      drive(0, 1'b1, 9'h096); tick();
      drive(0, 1'b0, 9'h0);
      repeat (38) tick();
      check("pp_count_before", cnt_of(0), 2);
      drive(0, 1'b1, 9'h0E7);
      tick();
      drive(0, 1'b0, 9'h0);
      check("pp_count_after", cnt_of(0), 2);
      wait_idle(0, 600);

      // reset during bit 3 of frame 1 with two bytes queued
      expect_frame(0, 9'h011, 1'b0);
      drive(0, 1'b1, 9'h011); tick();
      drive(0, 1'b1, 9'h022); tick();
      drive(0, 1'b1, 9'h033); tick();
      drive(0, 1'b0, 9'h0);
      repeat (12) tick();
      d0 = done_cnt[0];
      rst = 1'b1;
      tick();
      check("mid_rst_serial", int'(bus0.o_Tx_Serial), 1);
      check("mid_rst_active", int'(bus0.o_Tx_Active), 0);
      check("mid_rst_count", cnt_of(0), 0);
      check("mid_rst_ready", int'(bus0.o_Tx_Ready), 1);
      rst = 1'b0;
      exp_q.delete();
      repeat (60) tick();
      check("mid_rst_no_done", done_cnt[0] - d0, 0);
      expect_frame(0, 9'h0C3, 1'b0);
      push1(0, 9'h0C3);
      wait_idle(0, 200);

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
